// File: rtl/mux_scan.sv
// Registered N_CH-way channel selector with a ready/valid output. SINGLE mode
// delivers one channel; SCAN mode delivers all N_CH channels starting at sel, wrapping.
module mux_scan #(
    parameter int N_CH = 16,
    parameter int W    = 1,
    localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic              start,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CNT_W = $clog2(N_CH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             scan_q, scan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] next_ch;
    logic             sel_ok, accept, last;

    // Comparison-based mux keeps non-power-of-two N_CH free of out-of-range indexing.
    function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] v,
                                          input logic [SEL_W-1:0]  idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++)
            if (idx == SEL_W'(k)) r = v[k*W +: W];
        return r;
    endfunction

    assign next_ch = (ch_q == SEL_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
    assign sel_ok  = {1'b0, sel} < (SEL_W + 1)'(N_CH);
    assign accept  = valid_q & out_ready;
    assign last    = !scan_q || (cnt_q == CNT_W'(N_CH));

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        scan_d  = scan_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (sel_ok) begin
                        state_d = ACTIVE;
                        data_d  = pick(in, sel);
                        ch_d    = sel;
                        valid_d = 1'b1;
                        scan_d  = mode;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // Non-final scan accepts reload on the same edge, so there is no bubble.
                if (accept) begin
                    if (last) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        ch_d   = next_ch;
                        data_d = pick(in, next_ch);
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            scan_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            scan_q  <= scan_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == ACTIVE);
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: a 16x1 instance for single/scan/stall/reset cases
// and a 12x8 instance for the out-of-range select and wide-channel case.
module tb_mux_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] in_a = '0;
    logic [3:0]  sel_a = '0, och_a;
    logic        mode_a = 1'b0, start_a = 1'b0, rdy_a = 1'b0;
    logic        od_a, ov_a, busy_a, done_a, err_a;

    logic [95:0] in_b = '0;
    logic [3:0]  sel_b = '0, och_b;
    logic        mode_b = 1'b0, start_b = 1'b0, rdy_b = 1'b0;
    logic [7:0]  od_b;
    logic        ov_b, busy_b, done_b, err_b;

    mux_scan #(.N_CH(16), .W(1)) u_a (
        .clk(clk), .rst(rst), .in(in_a), .sel(sel_a), .mode(mode_a), .start(start_a),
        .out_data(od_a), .out_ch(och_a), .out_valid(ov_a), .out_ready(rdy_a),
        .busy(busy_a), .done(done_a), .err(err_a));

    mux_scan #(.N_CH(12), .W(8)) u_b (
        .clk(clk), .rst(rst), .in(in_b), .sel(sel_b), .mode(mode_b), .start(start_b),
        .out_data(od_b), .out_ch(och_b), .out_valid(ov_b), .out_ready(rdy_b),
        .busy(busy_b), .done(done_b), .err(err_b));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] edge_in;
    int exp_ch, acc;
    logic exp_d;
    logic [3:0] pat;

    initial begin
        // reset state on both instances
        #3;
        chk("rst_data_a", 32'(od_a), 0);
        chk("rst_ch_a", 32'(och_a), 0);
        chk("rst_flags_a", {ov_a, busy_a, done_a, err_a}, 0);
        chk("rst_flags_b", {od_b, ov_b, busy_b, done_b, err_b}, 0);
        step(); step();

        // single, sel=15, start on the first edge after reset release
        rst = 1'b0; in_a = 16'h8001; mode_a = 1'b0; sel_a = 4'd15; start_a = 1'b1; rdy_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("single_data", 32'(od_a), 1);
        chk("single_ch", 32'(och_a), 15);
        chk("single_vb", {ov_a, busy_a, done_a}, 3'b110);
        step();
        chk("single_done", {ov_a, busy_a, done_a}, 3'b001);
        step();
        chk("single_done_pulse", 32'(done_a), 0);

        // scan from 14, ready always high
        in_a = 16'hA5C3; mode_a = 1'b1; sel_a = 4'd14; start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("scan_ch%0d", i), 32'(och_a), (14 + i) % 16);
            chk($sformatf("scan_d%0d", i), 32'(od_a), 32'(in_a[(14 + i) % 16]));
            chk($sformatf("scan_vd%0d", i), {ov_a, done_a}, 2'b10);
            step();
        end
        chk("scan_done", {ov_a, busy_a, done_a}, 3'b001);
        step();

        // scan from 2 with ready pattern 1,0,0,1 and input changing every cycle
        pat = 4'b1001;
        in_a = 16'h3C5A; sel_a = 4'd2; start_a = 1'b1; rdy_a = 1'b0;
        edge_in = in_a;
        step();
        start_a = 1'b0;
        exp_ch = 2; exp_d = edge_in[2]; acc = 0;
        for (int k = 0; k < 80 && acc < 16; k++) begin
            chk("stall_ch", 32'(och_a), 32'(exp_ch));
            chk("stall_d", 32'(od_a), 32'(exp_d));
            chk("stall_vd", {ov_a, done_a}, 2'b10);
            rdy_a = pat[k % 4];
            in_a = 16'($urandom);
            edge_in = in_a;
            step();
            if (pat[k % 4]) begin
                acc++;
                if (acc < 16) begin
                    exp_ch = (exp_ch + 1) % 16;
                    exp_d = edge_in[exp_ch];
                end
            end
        end
        chk("stall_done", {ov_a, busy_a, done_a}, 3'b001);
        rdy_a = 1'b1;
        step();

        // out-of-range select and wide channel on the 12x8 instance
        for (int k = 0; k < 12; k++) in_b[k*8 +: 8] = 8'(8'hA0 + k);
        sel_b = 4'd13; start_b = 1'b1; rdy_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("err13", {err_b, busy_b, ov_b, done_b}, 4'b1000);
        step();
        chk("err13_pulse", 32'(err_b), 0);
        sel_b = 4'd12; start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("err12", {err_b, busy_b, ov_b}, 3'b100);
        chk("err12_hold", 32'(od_b), 0);
        sel_b = 4'd11; mode_b = 1'b0; start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("b_data", 32'(od_b), 32'hAB);
        chk("b_ch", 32'(och_b), 11);
        chk("b_flags", {ov_b, busy_b, err_b}, 3'b110);
        step();
        chk("b_done", {ov_b, done_b, err_b}, 3'b010);

        // reset mid-scan after 5 accepted samples
        in_a = 16'h0008; mode_a = 1'b1; sel_a = 4'd0; start_a = 1'b1; rdy_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_ch", 32'(och_a), 5);
        rst = 1'b1;
        #1;
        chk("midrst_out", {od_a, och_a}, 0);
        chk("midrst_flags", {ov_a, busy_a, done_a, err_a}, 0);
        step();
        chk("midrst_nodone", {done_a, ov_a}, 0);
        rst = 1'b0; mode_a = 1'b0; sel_a = 4'd3; start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("post_rst_data", 32'(od_a), 1);
        chk("post_rst_ch", 32'(och_a), 3);
        chk("post_rst_v", {ov_a, busy_a}, 2'b11);
        step();
        chk("post_rst_done", {ov_a, done_a}, 2'b01);

        // start held through the final accept of a single request
        in_a = 16'h0002; mode_a = 1'b0; sel_a = 4'd1; start_a = 1'b1;
        step();
        chk("hold_load", {od_a, ov_a, busy_a}, 3'b111);
        step();
        chk("hold_final", {ov_a, busy_a, done_a}, 3'b001);
        step();
        start_a = 1'b0;
        chk("hold_restart", {ov_a, busy_a, done_a}, 3'b110);
        chk("hold_restart_ch", 32'(och_a), 1);
        step();
        chk("hold_end", {ov_a, busy_a, done_a}, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
